sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single asynchronous SRAM between two requesters: the CPU memory port (driven by the instruction-sequencing control unit) and a program loader / debug port.
- Arbitrates between the two, latches the winning request, and generates the SRAM CE/OE/WE timing with parameterised wait states.
- Returns read data with a 4-phase req/done handshake.
- Sits between the datapath MAR/MDR logic and the top-level SRAM pins.

Parameters:
ADDR_W, 20, SRAM address width
DATA_W, 16, SRAM data width
RD_CYC, 2, cycles Mem_OE held low per read (>=1); data captured on last one
WR_CYC, 2, cycles Mem_WE held low per write (>=1)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-high
cpu_req  in  1  CPU request level (4-phase)
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data to CPU, valid while cpu_done=1
cpu_done  out  1  CPU access complete
ld_req, ld_we, ld_addr, ld_wdata, ld_rdata, ld_done  same as cpu_* for the loader port
ADDR  out  ADDR_W  SRAM address
Data_to_SRAM  out  DATA_W  write data to tristate buffer
Data_oe  out  1  tristate drive enable
Data_from_SRAM  in  DATA_W  SRAM read bus
Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active-low

Behaviour:
- Interface: one clock Clk. Reset is synchronous and active-high; polarity and synchronicity are fixed.
- All outputs are registered.
- Reset values:
  - Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE = 1.
  - Data_oe = 0; ADDR = 0; Data_to_SRAM = 0.
  - cpu_done = ld_done = 0; cpu_rdata = ld_rdata = 0.
  - State = IDLE; last_grant = LD, so CPU wins the first tie.
- IDLE:
  - Samples both req inputs. If either is high, the winner is chosen.
  - The winner's we/addr/wdata are latched into ADDR/Data_to_SRAM and grant is registered.
  - Next state is RD or WR. CE/UB/LB go 0 on entry to RD or WR and return to 1 on entry to IDLE.
- Arbitration: if only one req is high, that requester wins. If both are high, round-robin: the requester opposite last_grant wins. last_grant updates on every grant.
- RD:
  - Mem_OE = 0 for RD_CYC cycles, using a down-counter loaded with RD_CYC-1.
  - On the last RD cycle, Data_from_SRAM is captured into the granted port's rdata.
  - Next state DONE.
- WR:
  - Data_oe = 1 and Mem_WE = 0 for WR_CYC cycles.
  - Then WR_HOLD for 1 cycle: Mem_WE = 1, Data_oe = 1, ADDR unchanged (data/address hold).
  - Next state DONE.
- DONE:
  - Granted port's done = 1. OE/WE inactive, Data_oe = 0.
  - Stays in DONE until the granted req is low, then done = 0 and next state IDLE.
  - The non-granted req is ignored until IDLE.
- Latency, req rise to done: read 1+RD_CYC+1 cycles; write 1+WR_CYC+1+1 cycles.
- Latched values: changes to we/addr/wdata of a granted port after the grant cycle are ignored.
- The other port's rdata is unchanged by an access it did not own.
- Simultaneous events: a new req arriving in DONE from the other port waits, and is granted in the IDLE cycle that follows.
- Reset mid-operation: the next edge forces IDLE and all reset values. There is no SRAM glitch, because strobes are registered to inactive.
- Counter width is $clog2(max(RD_CYC,WR_CYC))+1, with no wrap-around.
- Mem_OE and Mem_WE are never low in the same cycle (assertion).

Optional Feature:
- Macro: SRAM_ARB_CPU_PRIO_EN.
- Defined: fixed priority. The CPU always wins when both requests are high; last_grant is unused.
- Undefined: round-robin as above.

Decomposition:
- Package sram_arb_pkg: state enum {IDLE, RD, WR, WR_HOLD, DONE}, grant enum {GNT_CPU, GNT_LD}, and a width helper for the counter.
- One natural sub-module, arb2_rr: 2-way arbiter that takes req[1:0] and last_grant and returns a one-hot grant. It holds the SRAM_ARB_CPU_PRIO_EN switch.

Test Plan:
1. Reset, then CPU read of 0x00012 with SRAM model holding 0xBEEF -> Mem_OE low for 2 cycles; cpu_done at cycle 4 with cpu_rdata=0xBEEF; ld_rdata stays 0.
2. Loader write 0x00003 <- 0x1234 -> Mem_WE low for 2 cycles, Data_oe high 3 cycles, ld_done at cycle 5; a subsequent CPU read of 0x00003 returns 0x1234.
3. Both reqs high in the same cycle, held through three back-to-back accesses -> grant order CPU, LD, CPU (macro undefined); with SRAM_ARB_CPU_PRIO_EN, order CPU, CPU, CPU.
4. CPU holds req high 5 cycles after done -> FSM stays in DONE and cpu_done stays 1; no second access until req falls and rises again.
5. Reset asserted during cycle 2 of a write -> next edge gives Mem_WE=1, Data_oe=0, State=IDLE, done=0.
6. Change cpu_addr from 0x00010 to 0x00020 in RD -> ADDR stays 0x00010 for the whole access.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and helpers for the SRAM arbiter slice.
//   state_e   : access sequencer states (IDLE, RD, WR, WR_HOLD, DONE)
//   grant_e   : which requester currently owns the SRAM (GNT_CPU / GNT_LD)
//   cnt_width : width of the wait-state down-counter for given RD/WR cycles
// Optional build macro used elsewhere in the slice: SRAM_ARB_CPU_PRIO_EN
// ---------------------------------------------------------------------------
package sram_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        WR_HOLD,
        DONE
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_LD  = 1'b1
    } grant_e;

    // The counter never has to hold more than max(RD_CYC, WR_CYC)-1; one
    // spare bit keeps it comfortably clear of wrap-around.
    function automatic int cnt_width(input int rd_cyc, input int wr_cyc);
        int m;
        m = (rd_cyc > wr_cyc) ? rd_cyc : wr_cyc;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sram_arbiter_arb2_rr.sv
// ---------------------------------------------------------------------------
// arb2_rr
// Two-way arbiter producing a one-hot grant.
//   req[1:0]   in  : request levels, bit 0 = CPU, bit 1 = loader
//   last_grant in  : requester granted most recently
//   gnt[1:0]   out : one-hot grant, same bit order as req (0 when idle)
// Build macro SRAM_ARB_CPU_PRIO_EN:
//   defined   -> fixed priority, CPU wins every tie, last_grant ignored
//   undefined -> round-robin, the port opposite last_grant wins a tie
// ---------------------------------------------------------------------------
module arb2_rr
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  grant_e     last_grant,
    output logic [1:0] gnt
);

`ifdef SRAM_ARB_CPU_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // A lone request always wins; only a tie needs the priority rule.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
`ifdef SRAM_ARB_CPU_PRIO_EN
                gnt = 2'b01;
`else
                gnt = (last_grant == GNT_LD) ? 2'b01 : 2'b10;
`endif
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Shares one asynchronous SRAM between the CPU memory port and the program
// loader / debug port. Each port uses a 4-phase req/done handshake; the
// winning request is latched and the SRAM strobes are sequenced with
// RD_CYC / WR_CYC wait states. Every output is registered.
// Ports:
//   Clk, Reset                  : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata       : CPU request level and access fields
//   cpu_rdata, cpu_done         : CPU read data (valid while done) and done
//   ld_*                        : same set for the loader port
//   ADDR, Data_to_SRAM, Data_oe : SRAM address, write data, bus drive enable
//   Data_from_SRAM              : SRAM read bus
//   Mem_CE/UB/LB/OE/WE          : SRAM strobes, active-low
// Build macro SRAM_ARB_CPU_PRIO_EN selects fixed CPU priority on ties
// (see arb2_rr); without it ties are resolved round-robin.
// ---------------------------------------------------------------------------
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16,
    parameter int RD_CYC = 2,
    parameter int WR_CYC = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_done,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    output logic              Data_oe,
    input  logic [DATA_W-1:0] Data_from_SRAM,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE
);

    localparam int CNT_W = cnt_width(RD_CYC, WR_CYC);

    state_e             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    grant_e             grant, grant_d;
    grant_e             last_grant, last_grant_d;
    logic [1:0]         gnt_vec;
    logic               win_we;
    logic               owner_req;

    logic [ADDR_W-1:0]  addr_d;
    logic [DATA_W-1:0]  wdata_d;
    logic [DATA_W-1:0]  cpu_rdata_d, ld_rdata_d;
    logic               cpu_done_d, ld_done_d;
    logic               ce_d, oe_d, we_d, doe_d;

    arb2_rr u_arb (
        .req        ({ld_req, cpu_req}),
        .last_grant (last_grant),
        .gnt        (gnt_vec)
    );

    // State register plus the registered copies of every output, so the
    // SRAM pins never see combinational glitches and reset parks them idle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            cnt          <= '0;
            grant        <= GNT_CPU;
            last_grant   <= GNT_LD;
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            cpu_rdata    <= '0;
            ld_rdata     <= '0;
            cpu_done     <= 1'b0;
            ld_done      <= 1'b0;
            Data_oe      <= 1'b0;
            Mem_CE       <= 1'b1;
            Mem_UB       <= 1'b1;
            Mem_LB       <= 1'b1;
            Mem_OE       <= 1'b1;
            Mem_WE       <= 1'b1;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            grant        <= grant_d;
            last_grant   <= last_grant_d;
            ADDR         <= addr_d;
            Data_to_SRAM <= wdata_d;
            cpu_rdata    <= cpu_rdata_d;
            ld_rdata     <= ld_rdata_d;
            cpu_done     <= cpu_done_d;
            ld_done      <= ld_done_d;
            Data_oe      <= doe_d;
            Mem_CE       <= ce_d;
            Mem_UB       <= ce_d;
            Mem_LB       <= ce_d;
            Mem_OE       <= oe_d;
            Mem_WE       <= we_d;
        end
    end

    // Next-state logic. Grants happen only from IDLE, so a request from the
    // other port that shows up during an access simply waits for IDLE. The
    // counter is loaded with CYC-1 and the phase ends when it reaches zero.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        grant_d      = grant;
        last_grant_d = last_grant;
        win_we       = gnt_vec[1] ? ld_we : cpu_we;
        owner_req    = (grant == GNT_CPU) ? cpu_req : ld_req;
        case (state)
            IDLE: begin
                if (gnt_vec != 2'b00) begin
                    grant_d      = gnt_vec[1] ? GNT_LD : GNT_CPU;
                    last_grant_d = grant_d;
                    if (win_we) begin
                        state_d = WR;
                        cnt_d   = CNT_W'(WR_CYC - 1);
                    end else begin
                        state_d = RD;
                        cnt_d   = CNT_W'(RD_CYC - 1);
                    end
                end
            end
            RD: begin
                if (cnt == '0) state_d = DONE;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            WR: begin
                if (cnt == '0) state_d = WR_HOLD;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            WR_HOLD: state_d = DONE;
            DONE: begin
                if (!owner_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic computes the value each output register takes at the next
    // edge. Strobes follow the state being entered, so CE drops together with
    // OE/WE and only rises again on the way back to IDLE. Read data is taken
    // on the final OE-low cycle and written only into the owning port.
    always_comb begin
        addr_d      = ADDR;
        wdata_d     = Data_to_SRAM;
        cpu_rdata_d = cpu_rdata;
        ld_rdata_d  = ld_rdata;
        if (state == IDLE && gnt_vec != 2'b00) begin
            addr_d  = gnt_vec[1] ? ld_addr  : cpu_addr;
            wdata_d = gnt_vec[1] ? ld_wdata : cpu_wdata;
        end
        if (state == RD && cnt == '0) begin
            if (grant == GNT_CPU) cpu_rdata_d = Data_from_SRAM;
            else                  ld_rdata_d  = Data_from_SRAM;
        end
        ce_d       = (state_d == IDLE);
        oe_d       = (state_d != RD);
        we_d       = (state_d != WR);
        doe_d      = (state_d == WR) || (state_d == WR_HOLD);
        cpu_done_d = (state_d == DONE) && (grant_d == GNT_CPU);
        ld_done_d  = (state_d == DONE) && (grant_d == GNT_LD);
    end

    // Driving OE and WE low together would let the SRAM and the tristate
    // buffer fight over the data bus.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            assert (Mem_OE || Mem_WE);
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Self-checking bench for sram_arbiter: a behavioural async SRAM, a
// reference memory plus grant-order model, and a scoreboard queue drained by
// a monitor on each rising done. Honours SRAM_ARB_CPU_PRIO_EN when defined.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int RD_CYC = 2;
    localparam int WR_CYC = 2;
    localparam int P_CPU  = 0;
    localparam int P_LD   = 1;

    typedef struct {
        int              port;
        bit              we;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_done;
    logic              ld_req = 1'b0, ld_we = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [DATA_W-1:0] ld_wdata = '0;
    logic [DATA_W-1:0] ld_rdata;
    logic              ld_done;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_to_SRAM;
    logic              Data_oe;
    logic [DATA_W-1:0] Data_from_SRAM;
    logic              Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] sram    [0:255];
    logic [DATA_W-1:0] ref_mem [0:255];
    exp_t              sb[$];
    int                ref_last = P_LD;
    logic [DATA_W-1:0] model_cpu_rdata = '0;
    logic [DATA_W-1:0] model_ld_rdata  = '0;
    bit                overlap_seen = 1'b0;

    sram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_CYC(RD_CYC), .WR_CYC(WR_CYC)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_rdata(ld_rdata), .ld_done(ld_done),
        .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_oe(Data_oe),
        .Data_from_SRAM(Data_from_SRAM),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
    );

    always #5 Clk = ~Clk;

    // Asynchronous SRAM: drives the bus while selected with OE low, and
    // stores the driven data on any clock edge seen with WE low.
    assign Data_from_SRAM = (!Mem_CE && !Mem_OE) ? sram[ADDR[7:0]] : '0;

    always @(posedge Clk) begin
        if (!Mem_CE && !Mem_WE && Data_oe) sram[ADDR[7:0]] <= Data_to_SRAM;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Reference model: accesses are served one at a time in grant order.
    function automatic void model_issue(input int port, input bit we,
                                        input logic [ADDR_W-1:0] a,
                                        input logic [DATA_W-1:0] d);
        exp_t e;
        e.port = port;
        e.we   = we;
        if (we) ref_mem[a[7:0]] = d;
        e.rdata = we ? '0 : ref_mem[a[7:0]];
        sb.push_back(e);
        ref_last = port;
    endfunction

    function automatic int model_tie_winner();
`ifdef SRAM_ARB_CPU_PRIO_EN
        return P_CPU;
`else
        return (ref_last == P_LD) ? P_CPU : P_LD;
`endif
    endfunction

    // One 4-phase handshake on a port; with measure set, latency, strobe
    // lengths and address stability of this single access are checked too.
    task automatic applyStimulus(input int port, input bit we,
                                 input logic [ADDR_W-1:0] addr,
                                 input logic [DATA_W-1:0] wdata,
                                 input bit measure, input int hold_extra,
                                 input bit change_addr);
        int cyc = 1, oe_lo = 0, we_lo = 0, doe_hi = 0, rel = 0;
        bit got = 1'b0, addr_ok = 1'b1, hold_ok = 1'b1, done_now;
        if (port == P_CPU) begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
        end else begin
            ld_we = we; ld_addr = addr; ld_wdata = wdata; ld_req = 1'b1;
        end
        while (!got && cyc < 60) begin
            @(negedge Clk);
            cyc++;
            if (!Mem_OE) oe_lo++;
            if (!Mem_WE) we_lo++;
            if (Data_oe) doe_hi++;
            if (!Mem_CE && ADDR !== addr) addr_ok = 1'b0;
            if (change_addr && cyc == 2) begin
                if (port == P_CPU) cpu_addr = addr ^ 20'h00030;
                else               ld_addr  = addr ^ 20'h00030;
            end
            got = (port == P_CPU) ? cpu_done : ld_done;
        end
        checkOutput(port == P_CPU ? "cpu_done_seen" : "ld_done_seen", 32'(got), 32'd1);
        if (measure) begin
            checkOutput("latency", cyc, we ? 1 + WR_CYC + 1 + 1 : 1 + RD_CYC + 1);
            checkOutput("oe_low_cycles", oe_lo, we ? 0 : RD_CYC);
            checkOutput("we_low_cycles", we_lo, we ? WR_CYC : 0);
            checkOutput("data_oe_cycles", doe_hi, we ? WR_CYC + 1 : 0);
            checkOutput("addr_stable", 32'(addr_ok), 32'd1);
        end
        if (hold_extra > 0) begin
            repeat (hold_extra) begin
                @(negedge Clk);
                done_now = (port == P_CPU) ? cpu_done : ld_done;
                if (!done_now || !Mem_OE || !Mem_WE) hold_ok = 1'b0;
            end
            checkOutput("done_held_no_reaccess", 32'(hold_ok), 32'd1);
        end
        if (port == P_CPU) cpu_req = 1'b0;
        else               ld_req  = 1'b0;
        done_now = 1'b1;
        while (done_now && rel < 20) begin
            @(negedge Clk);
            rel++;
            done_now = (port == P_CPU) ? cpu_done : ld_done;
        end
        checkOutput("done_release", 32'(done_now), 32'd0);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_strobes", {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}, 32'h1f);
        checkOutput("rst_data_oe", 32'(Data_oe), 32'd0);
        checkOutput("rst_addr", 32'(ADDR), 32'd0);
        checkOutput("rst_wdata", 32'(Data_to_SRAM), 32'd0);
        checkOutput("rst_done", {cpu_done, ld_done}, 32'd0);
        checkOutput("rst_rdata", {cpu_rdata, ld_rdata}, 32'd0);
    endtask

    // Monitor: every rising done pops the next expected access and checks the
    // owner, its read data, and that the other port's rdata did not move.
    initial begin
        exp_t e;
        logic prev_cpu = 1'b0, prev_ld = 1'b0;
        forever begin
            @(negedge Clk);
            if (!Mem_OE && !Mem_WE) overlap_seen = 1'b1;
            if ((cpu_done && !prev_cpu) || (ld_done && !prev_ld)) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("grant_owner", cpu_done ? P_CPU : P_LD, e.port);
                    if (e.port == P_CPU && !e.we) model_cpu_rdata = e.rdata;
                    if (e.port == P_LD  && !e.we) model_ld_rdata  = e.rdata;
                    checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(model_cpu_rdata));
                    checkOutput("ld_rdata", 32'(ld_rdata), 32'(model_ld_rdata));
                end
            end
            prev_cpu = cpu_done;
            prev_ld  = ld_done;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int kind, w, l;
        bit we0, we1;
        logic [ADDR_W-1:0] a0, a1;
        logic [DATA_W-1:0] d0, d1;

        for (int i = 0; i < 256; i++) begin
            d0 = 16'($urandom);
            sram[i] = d0;
            ref_mem[i] = d0;
        end
        sram[8'h12] = 16'hBEEF;
        ref_mem[8'h12] = 16'hBEEF;

        repeat (3) @(negedge Clk);
        checkResetValues();
        Reset = 1'b0;
        @(negedge Clk);

        // Read with known contents, write then read-back
        model_issue(P_CPU, 1'b0, 20'h00012, '0);
        applyStimulus(P_CPU, 1'b0, 20'h00012, '0, 1'b1, 0, 1'b0);
        model_issue(P_LD, 1'b1, 20'h00003, 16'h1234);
        applyStimulus(P_LD, 1'b1, 20'h00003, 16'h1234, 1'b1, 0, 1'b0);
        model_issue(P_CPU, 1'b0, 20'h00003, '0);
        applyStimulus(P_CPU, 1'b0, 20'h00003, '0, 1'b1, 0, 1'b0);

        // Request held after done, then address changed mid-read
        model_issue(P_CPU, 1'b0, 20'h00012, '0);
        applyStimulus(P_CPU, 1'b0, 20'h00012, '0, 1'b1, 5, 1'b0);
        model_issue(P_CPU, 1'b0, 20'h00010, '0);
        applyStimulus(P_CPU, 1'b0, 20'h00010, '0, 1'b1, 0, 1'b1);

        // Reset in the second cycle of a loader write (scratch address)
        ld_we = 1'b1; ld_addr = 20'h000F0; ld_wdata = 16'h5A5A; ld_req = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("midrst_we", 32'(Mem_WE), 32'd1);
        checkOutput("midrst_data_oe", 32'(Data_oe), 32'd0);
        checkOutput("midrst_ce", 32'(Mem_CE), 32'd1);
        checkOutput("midrst_done", {cpu_done, ld_done}, 32'd0);
        ld_req = 1'b0;
        Reset = 1'b0;
        ref_last = P_LD;
        model_cpu_rdata = '0;
        model_ld_rdata = '0;
        @(negedge Clk);

        // Tie after reset, then a lone CPU access
        w = model_tie_winner();
        l = (w == P_CPU) ? P_LD : P_CPU;
        model_issue(w, 1'b0, w == P_CPU ? 20'h00012 : 20'h00003, '0);
        model_issue(l, 1'b0, l == P_CPU ? 20'h00012 : 20'h00003, '0);
        fork
            applyStimulus(P_CPU, 1'b0, 20'h00012, '0, 1'b0, 0, 1'b0);
            applyStimulus(P_LD, 1'b0, 20'h00003, '0, 1'b0, 0, 1'b0);
        join
        model_issue(P_CPU, 1'b1, 20'h00040, 16'hC0DE);
        applyStimulus(P_CPU, 1'b1, 20'h00040, 16'hC0DE, 1'b1, 0, 1'b0);

        // Randomised mix of lone accesses and ties
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            we0 = 1'($urandom); we1 = 1'($urandom);
            a0 = 20'($urandom_range(0, 127)); a1 = 20'($urandom_range(0, 127));
            d0 = 16'($urandom); d1 = 16'($urandom);
            if (kind < 2) begin
                model_issue(kind, we0, a0, d0);
                applyStimulus(kind, we0, a0, d0, 1'b1, 0, 1'b0);
            end else begin
                w = model_tie_winner();
                if (w == P_CPU) begin
                    model_issue(P_CPU, we0, a0, d0);
                    model_issue(P_LD, we1, a1, d1);
                end else begin
                    model_issue(P_LD, we1, a1, d1);
                    model_issue(P_CPU, we0, a0, d0);
                end
                fork
                    applyStimulus(P_CPU, we0, a0, d0, 1'b0, 0, 1'b0);
                    applyStimulus(P_LD, we1, a1, d1, 1'b0, 0, 1'b0);
                join
            end
        end

        repeat (3) @(negedge Clk);
        checkOutput("scoreboard_drained", sb.size(), 32'd0);
        checkOutput("oe_we_overlap", 32'(overlap_seen), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
